// File: rtl/uart_rx_axis_packer.sv
`timescale 1ns/1ps
// Packs UART bytes into AXI-Stream packets. Each byte is held until the next one or an idle timeout,
// so tlast can be attached; exits through a first-word-fall-through FIFO that drops on full.

// Generic FWFT FIFO: push visible one cycle later; discards a push when full unless a pop frees a slot.
module packer_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  output logic                       wr_drop,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_q;
  logic          full, do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign rd_vld  = (level_q != '0);
  assign do_pop  = rd_vld && rd_rdy;
  assign do_push = wr_vld && (!full || do_pop);
  assign wr_drop = wr_vld && full && !do_pop;
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// Hold register + idle timer decide tlast; byte k emerges one cycle after byte k+1 or the timeout.
module uart_rx_axis_packer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int MAX_PKT     = 64,
  parameter int IDLE_CYCLES = 8680
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_valid,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  input  logic                     m_axis_ready,
  output logic                     m_axis_last,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int TW = $clog2(IDLE_CYCLES);
  localparam int PW = $clog2(MAX_PKT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [PW-1:0] P_MAX  = PW'(MAX_PKT);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] hold_dat;
  logic [PW-1:0]    pkt_cnt;
  logic [TW-1:0]    timer;
  logic             timeout, push_vld, push_last, push_drop;
  logic [WIDTH:0]   rd_dat;

  assign timeout   = (state == S_HOLD) && (timer == T_LAST);
  assign push_vld  = (state == S_HOLD) && (rx_valid || timeout);
  // A new byte in the timeout cycle wins, so last then comes only from the packet-length limit.
  assign push_last = rx_valid ? (pkt_cnt == P_MAX) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_dat <= '0;
      pkt_cnt  <= '0;
      timer    <= '0;
    end else if (rx_valid) begin
      state    <= S_HOLD;
      hold_dat <= rx_data;
      timer    <= '0;
      if (state == S_IDLE || pkt_cnt == P_MAX) pkt_cnt <= PW'(1);
      else                                     pkt_cnt <= pkt_cnt + PW'(1);
    end else if (state == S_HOLD) begin
      if (timeout) begin
        state   <= S_IDLE;
        pkt_cnt <= '0;
        timer   <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            overflow <= 1'b0;
    else if (push_drop) overflow <= 1'b1;
  end

  packer_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (push_vld),
    .wr_dat  ({push_last, hold_dat}),
    .wr_drop (push_drop),
    .rd_vld  (m_axis_valid),
    .rd_rdy  (m_axis_ready),
    .rd_dat  (rd_dat),
    .level   (fifo_level)
  );

  assign m_axis_last = rd_dat[WIDTH];
  assign m_axis_data = rd_dat[WIDTH-1:0];
endmodule

// File: tb/tb_uart_rx_axis_packer.sv
`timescale 1ns/1ps
// Scoreboard bench: directed byte sequences queue expected beats; a negedge monitor checks each accepted beat.
module tb_uart_rx_axis_packer;
  logic       clk = 1'b0;
  logic       rst, rx_valid, ready, sel;
  logic [7:0] rx_data;

  logic [7:0] d3_data, d8_data, m_data;
  logic       d3_valid, d8_valid, d3_last, d8_last, d3_ovf, d8_ovf;
  logic [2:0] d3_level, d8_level, m_level;
  logic       m_valid, m_last, m_ovf;

  logic [8:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] peak;

  always #5 clk = ~clk;

  uart_rx_axis_packer #(.WIDTH(8), .DEPTH(4), .MAX_PKT(3), .IDLE_CYCLES(20)) dut3 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_axis_data(d3_data), .m_axis_valid(d3_valid), .m_axis_ready(ready),
    .m_axis_last(d3_last), .overflow(d3_ovf), .fifo_level(d3_level));

  uart_rx_axis_packer #(.WIDTH(8), .DEPTH(4), .MAX_PKT(8), .IDLE_CYCLES(20)) dut8 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_axis_data(d8_data), .m_axis_valid(d8_valid), .m_axis_ready(ready),
    .m_axis_last(d8_last), .overflow(d8_ovf), .fifo_level(d8_level));

  assign m_data  = sel ? d8_data  : d3_data;
  assign m_valid = sel ? d8_valid : d3_valid;
  assign m_last  = sel ? d8_last  : d3_last;
  assign m_ovf   = sel ? d8_ovf   : d3_ovf;
  assign m_level = sel ? d8_level : d3_level;

  // Monitor: every beat accepted at the coming edge must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && m_valid && ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", m_data, m_last);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({m_last, m_data} !== e) begin
          n_err++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                   m_data, m_last, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (m_level > peak) peak = m_level;
    end
  endtask

  // Called #1 after an edge; the byte is captured at the next edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || m_valid) && cyc < 200) begin
      idle(1);
      cyc++;
    end
    idle(25);
    check({name, "_missing_beats"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ready = 1'b1; sel = 1'b0; peak = '0;
    idle(2);
    rst = 1'b0;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last",  32'(m_last),  32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_level", 32'(m_level), 32'd0);
    check("rst_ovf",   32'(m_ovf),   32'd0);

    // Single byte closed by timeout: pushed at the 20th edge after capture.
    exp_q.push_back({1'b1, 8'hA5});
    send(8'hA5);
    idle(19);
    check("single_valid_early", 32'(m_valid), 32'd0);
    idle(1);
    check("single_valid_on_time", 32'(m_valid), 32'd1);
    drain("single");

    // Four bytes: third hits the 3-beat limit, fourth closes by timeout.
    do_reset();
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'h03});
    exp_q.push_back({1'b1, 8'h04});
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      if (i != 4) idle(4);
    end
    drain("maxpkt");

    // Second byte on the timeout cycle wins over the timeout.
    do_reset();
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'h66});
    send(8'h55);
    idle(19);
    send(8'h66);
    drain("timeout_race");

    // Reset mid-packet discards FIFO and hold; rx_valid during reset ignored.
    do_reset();
    ready = 1'b0;
    send(8'h01);
    idle(4);
    send(8'h02);
    idle(2);
    check("midrst_level_before", 32'(m_level), 32'd1);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    idle(1);
    rst = 1'b0; rx_valid = 1'b0;
    check("midrst_level", 32'(m_level), 32'd0);
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_ovf",   32'(m_ovf),   32'd0);
    ready = 1'b1;
    exp_q.push_back({1'b1, 8'h77});
    send(8'h77);
    drain("midrst");

    // Full FIFO with push and pop on the same edge.
    do_reset();
    ready = 1'b0;
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b0, 8'hC1});
    exp_q.push_back({1'b1, 8'hC2});
    exp_q.push_back({1'b0, 8'hC3});
    exp_q.push_back({1'b0, 8'hC4});
    exp_q.push_back({1'b1, 8'hC5});
    for (int i = 0; i < 5; i++) begin
      send(8'hC0 + 8'(i));
      idle(4);
    end
    check("full_level",     32'(m_level), 32'd4);
    check("full_head_data", 32'(m_data),  32'hC0);
    check("full_ovf",       32'(m_ovf),   32'd0);
    ready = 1'b1;
    send(8'hC5);
    check("pushpop_level", 32'(m_level), 32'd4);
    check("pushpop_ovf",   32'(m_ovf),   32'd0);
    drain("pushpop");

    // Overflow with an 8-beat packet limit and a stalled sink.
    sel = 1'b1;
    do_reset();
    peak = '0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 6; i++) begin
      send(8'h10 + 8'(i));
      if (i != 5) idle(4);
    end
    idle(25);
    check("ovf_set",   32'(m_ovf),   32'd1);
    check("ovf_level", 32'(m_level), 32'd4);
    check("ovf_peak",  32'(peak),    32'd4);
    ready = 1'b1;
    drain("ovf");
    check("ovf_sticky",      32'(m_ovf),   32'd1);
    check("ovf_level_empty", 32'(m_level), 32'd0);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_axis_packer.md
UART_RX_AXIS_PACKER -- requirements
Module: uart_rx_axis_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of UART byte and AXI-Stream beat.
REQ-002 SHALL have parameter DEPTH, default 16: output FIFO entries, power of 2, >=2.
REQ-003 SHALL have parameter MAX_PKT, default 64: maximum beats per packet, >=1.
REQ-004 SHALL have parameter IDLE_CYCLES, default 8680: idle clocks (2 chars at 50 MHz/115200) that close a packet, >=2.
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port rx_data  in  WIDTH  received byte from the UART receiver.
REQ-008 SHALL have port rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-009 SHALL have port m_axis_data  out  WIDTH  stream beat data.
REQ-010 SHALL have port m_axis_valid  out  1  beat available.
REQ-011 SHALL have port m_axis_ready  in  1  downstream accepts beat.
REQ-012 SHALL have port m_axis_last  out  1  beat ends packet.
REQ-013 SHALL have port overflow  out  1  sticky, byte lost because FIFO full.
REQ-014 SHALL have port fifo_level  out  $clog2(DEPTH)+1  FIFO entry count, 0..DEPTH.

Function
REQ-015 SHALL hold back the newest byte in a hold register so tlast can be attached at packet close; FSM states IDLE (hold empty) and HOLD (hold full).
REQ-016 IDLE + rx_valid: SHALL load hold with rx_data, set pkt_cnt=1, clear idle timer, go to HOLD.
REQ-017 HOLD + rx_valid: SHALL push {held byte, last=(pkt_cnt==MAX_PKT)} into FIFO, load hold with rx_data, clear timer, set pkt_cnt to 1 if pkt_cnt==MAX_PKT else pkt_cnt+1; stay in HOLD.
REQ-018 HOLD, no rx_valid: SHALL increment timer; when timer==IDLE_CYCLES-1, push {held byte, last=1}, clear pkt_cnt and timer, go to IDLE.
REQ-019 rx_valid in the timeout cycle SHALL win: REQ-017 applies, no last generated by timeout.
REQ-020 Timer and pkt_cnt SHALL saturate/wrap only as defined above; timer never counts in IDLE.
REQ-021 FIFO SHALL be first-word-fall-through: an entry pushed at edge N drives m_axis_valid=1 and its data/last from cycle N+1.
REQ-022 Pop SHALL occur on any edge with m_axis_valid && m_axis_ready; m_axis_data/m_axis_last SHALL be stable while valid && !ready.
REQ-023 m_axis_valid SHALL equal (fifo_level != 0); it SHALL NOT depend combinationally on m_axis_ready.
REQ-024 Push when fifo_level==DEPTH with no pop same cycle: entry SHALL be discarded, overflow set to 1, FSM/pkt_cnt advance as if pushed.
REQ-025 Push and pop same cycle when full SHALL both succeed; fifo_level unchanged; no overflow.
REQ-026 Push and pop same cycle at any level SHALL leave fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-027 overflow SHALL clear only on rst.
REQ-028 End-to-end latency: byte k appears on stream only after byte k+1 arrives or IDLE_CYCLES idle clocks elapse, then 1 cycle.

Reset
REQ-029 rst=1 at a rising edge SHALL set: FSM IDLE, hold empty, timer 0, pkt_cnt 0, FIFO pointers 0, fifo_level 0, m_axis_valid 0, m_axis_last 0, m_axis_data 0, overflow 0.
REQ-030 Reset mid-packet SHALL discard the held byte and FIFO contents; rx_valid during rst SHALL be ignored; first byte after rst starts a new packet.

Verification
REQ-031 Bench params DEPTH=4, MAX_PKT=3, IDLE_CYCLES=20 unless stated; ready=1 unless stated.
REQ-032 Single byte 0xA5, then idle -> exactly one beat 0xA5 with last=1, valid 20 clocks after the rx_valid edge (+1 FWFT cycle).
REQ-033 Bytes 0x01,0x02,0x03,0x04 spaced 5 clocks -> beats 01(l=0),02(l=0),03(l=1),04(l=1 after timeout).
REQ-034 MAX_PKT=8, ready=0, bytes 0x10..0x15 spaced 5 clocks, then ready=1 -> beats 10,11,12,13 (last=0) only, overflow=1, fifo_level peaks at 4.
REQ-035 Byte 0x55, second byte 0x66 exactly on timeout cycle -> 55 has last=0, 66 has last=1 after its own timeout.
REQ-036 Bytes 0x01,0x02, rst pulse, byte 0x77 -> no 01/02 beats, overflow=0, single beat 77 last=1; separately full FIFO with push+pop same cycle -> no overflow, level stays 4.
